// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, fetch FSM
// states and the length / register-specifier decode helpers.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_OUT   = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;

    // Instruction length in bytes; unknown icodes occupy a single byte.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            IHALT, INOP, IRET:                 len = 4'd1;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:      len = 4'd2;
            IJXX, ICALL:                       len = 4'd9;
            IIRMOVQ, IRMMOVQ, IMRMOVQ:         len = 4'd10;
            default:                           len = 4'd1;
        endcase
        return len;
    endfunction

    // True when byte 1 carries the rA/rB register specifiers.
    function automatic logic need_regids(input logic [3:0] icode);
        logic need;
        case (icode)
            IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ,
            IOPQ, IPUSHQ, IPOPQ:               need = 1'b1;
            default:                           need = 1'b0;
        endcase
        return need;
    endfunction

    // Status implied by the opcode alone (address errors are handled separately).
    function automatic logic [2:0] icode_stat(input logic [3:0] icode);
        logic [2:0] st;
        if (icode > IPOPQ)
            st = STAT_INS;
        else if (icode == IHALT)
            st = STAT_HLT;
        else
            st = STAT_AOK;
        return st;
    endfunction

endpackage

// File: rtl/fetch_seq_align.sv
// Splits the instruction bytes following the opcode byte into rA, rB and valC.
module fetch_seq_align (
    input  logic [71:0] i_bytes,
    input  logic        i_need_regids,
    output logic [3:0]  o_rA,
    output logic [3:0]  o_rB,
    output logic [63:0] o_valC
);

    assign o_rA   = i_need_regids ? i_bytes[7:4] : 4'hF;
    assign o_rB   = i_need_regids ? i_bytes[3:0] : 4'hF;
    assign o_valC = i_need_regids ? i_bytes[71:8] : i_bytes[63:0];

endmodule

// File: rtl/fetch_seq.sv
// Y86-64 fetch sequencer: owns the PC, reads aligned 64-bit words from
// instruction memory, assembles the instruction and hands it to decode.
module fetch_seq
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [63:0] imem_rdata,
    input  logic        imem_err,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_icode,
    output logic [3:0]  out_ifun,
    output logic [3:0]  out_rA,
    output logic [3:0]  out_rB,
    output logic [63:0] out_valC,
    output logic [63:0] out_pc,
    output logic [63:0] out_valP,
    output logic [2:0]  out_stat,
    output logic        halted
);

    fetch_state_t r_state, w_state_nxt;
    logic [63:0]  r_pc, w_pc_nxt;
    logic [63:0]  r_pend_pc, w_pend_nxt;
    logic [1:0]   r_wcnt, w_wcnt_nxt;
    logic [79:0]  r_ibuf, w_ibuf_nxt;
    logic [2:0]   r_stat, w_stat_nxt;
    logic         r_discard, w_discard_nxt;
    logic         w_ibuf_we;

    logic [2:0]   w_off;
    logic [63:0]  w_w0;
    logic [4:0]   w_base;
    logic [79:0]  w_ins;
    logic [3:0]   w_icode;
    logic [3:0]   w_len;
    logic [4:0]   w_span;
    logic         w_more;
    logic [3:0]   w_out_len;
    logic [63:0]  w_valP;
    logic         w_valid;
    logic [3:0]   w_rA, w_rB;
    logic [63:0]  w_valC;

    // Word 0 is shifted so the opcode byte lands in buffer byte 0; later
    // words are placed at byte 8*wcnt - offset, which continues the stream.
    assign w_off      = r_pc[2:0];
    assign w_w0       = imem_rdata >> {w_off, 3'b000};
    assign w_base     = {r_wcnt, 3'b000} - {2'b00, w_off};
    assign w_ins      = {16'h0, imem_rdata} << {w_base, 3'b000};
    assign w_ibuf_nxt = (r_wcnt == 2'd0) ? {16'h0, w_w0} : (r_ibuf | w_ins);

    // The opcode is always in word 0, so the word count is known once it arrives.
    assign w_icode = (r_wcnt == 2'd0) ? w_w0[7:4] : r_ibuf[7:4];
    assign w_len   = instr_len(w_icode);
    assign w_span  = {2'b00, w_off} + {1'b0, w_len} + 5'd7;
    assign w_more  = (r_wcnt + 2'd1) < w_span[4:3];

    assign w_out_len = instr_len(r_ibuf[7:4]);
    assign w_valP    = r_pc + {60'h0, w_out_len};

    // Next-state and register updates for the FETCH / OUT / HALT sequence.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pend_nxt    = r_pend_pc;
        w_wcnt_nxt    = r_wcnt;
        w_stat_nxt    = r_stat;
        w_discard_nxt = r_discard;
        w_ibuf_we     = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        w_pc_nxt      = redirect_pc;
                        w_wcnt_nxt    = 2'd0;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_pend_nxt    = redirect_pc;
                        w_discard_nxt = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (r_discard) begin
                        w_pc_nxt      = r_pend_pc;
                        w_wcnt_nxt    = 2'd0;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_ibuf_we = 1'b1;
                        if (imem_err) begin
                            w_stat_nxt  = STAT_ADR;
                            w_state_nxt = S_OUT;
                        end else if (w_more) begin
                            w_wcnt_nxt = r_wcnt + 2'd1;
                        end else begin
                            w_stat_nxt  = icode_stat(w_icode);
                            w_state_nxt = S_OUT;
                        end
                    end
                end
            end
            S_OUT: begin
                // A redirect wins over a simultaneous out_ready: no transfer happens.
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_wcnt_nxt  = 2'd0;
                    w_state_nxt = S_FETCH;
                end else if (out_ready) begin
                    if (r_stat == STAT_AOK) begin
                        w_pc_nxt    = w_valP;
                        w_wcnt_nxt  = 2'd0;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_HALT;
                    end
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_FETCH;
        else
            r_state <= w_state_nxt;
    end

    // Control registers: PC, word counter, status and pending-redirect flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_wcnt    <= 2'd0;
            r_stat    <= 3'd0;
            r_discard <= 1'b0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_stat    <= w_stat_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    // Data registers: instruction buffer and the parked redirect target.
    always_ff @(posedge clk) begin
        r_pend_pc <= w_pend_nxt;
        if (w_ibuf_we)
            r_ibuf <= w_ibuf_nxt;
    end

    fetch_seq_align u_align (
        .i_bytes       (r_ibuf[79:8]),
        .i_need_regids (need_regids(r_ibuf[7:4])),
        .o_rA          (w_rA),
        .o_rB          (w_rB),
        .o_valC        (w_valC)
    );

    // Data outputs read as zero whenever no instruction is being presented.
    assign w_valid   = (r_state == S_OUT);
    assign imem_req  = (r_state == S_FETCH) && !rst;
    assign imem_addr = imem_req ? ({r_pc[63:3], 3'b000} + {59'h0, r_wcnt, 3'b000}) : 64'h0;
    assign out_valid = w_valid;
    assign halted    = (r_state == S_HALT);
    assign out_icode = w_valid ? r_ibuf[7:4] : 4'h0;
    assign out_ifun  = w_valid ? r_ibuf[3:0] : 4'h0;
    assign out_rA    = w_valid ? w_rA : 4'h0;
    assign out_rB    = w_valid ? w_rB : 4'h0;
    assign out_valC  = w_valid ? w_valC : 64'h0;
    assign out_pc    = w_valid ? r_pc : 64'h0;
    assign out_valP  = w_valid ? w_valP : 64'h0;
    assign out_stat  = w_valid ? r_stat : 3'd0;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a byte-addressed instruction memory model.
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [63:0] imem_rdata = 64'h0;
    logic        imem_err = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_icode, out_ifun, out_rA, out_rB;
    logic [63:0] out_valC, out_pc, out_valP;
    logic [2:0]  out_stat;
    logic        halted;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  mem [0:255];
    int          ack_delay = 0;
    logic        err_en = 1'b0;
    logic [63:0] err_addr = 64'h0;
    logic [63:0] req_log [$];

    fetch_seq #(.RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .imem_err       (imem_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_icode      (out_icode),
        .out_ifun       (out_ifun),
        .out_rA         (out_rA),
        .out_rB         (out_rB),
        .out_valC       (out_valC),
        .out_pc         (out_pc),
        .out_valP       (out_valP),
        .out_stat       (out_stat),
        .halted         (halted)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        logic [7:0]  b;
        b = {a[7:3], 3'b000};
        for (int k = 0; k < 8; k++)
            w[8*k +: 8] = mem[8'(b + 8'(k))];
        return w;
    endfunction

    function automatic logic [63:0] log_at(input int i);
        if (i < req_log.size())
            return req_log[i];
        return 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++)
            mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        req_log.delete();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_valid"}, 64'(out_valid), 64'h1);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Memory responder: acks after ack_delay wait cycles, logs each acked address.
    initial begin
        int rcnt;
        rcnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (imem_ack)
                rcnt = 0;
            if (imem_req) begin
                if (rcnt >= ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    imem_err   = err_en && (imem_addr == err_addr);
                    req_log.push_back(imem_addr);
                end else begin
                    imem_ack = 1'b0;
                    imem_err = 1'b0;
                    rcnt++;
                end
            end else begin
                imem_ack = 1'b0;
                imem_err = 1'b0;
                rcnt = 0;
            end
        end
    end

    initial begin
        int          lat;
        logic        bad;
        logic [63:0] snap_valC, snap_pc, snap_valP;
        logic [3:0]  snap_icode, snap_rB;

        clear_mem();
        repeat (2) @(negedge clk);
        check("rst_req",    64'(imem_req),  64'h0);
        check("rst_valid",  64'(out_valid), 64'h0);
        check("rst_halted", 64'(halted),    64'h0);
        check("rst_pc",     out_pc,         64'h0);
        check("rst_valC",   out_valC,       64'h0);
        check("rst_stat",   64'(out_stat),  64'h0);

        // irmovq $8, %r8 at pc 0: two words, valid after 2 cycles
        mem[0] = 8'h30; mem[1] = 8'hF8; mem[2] = 8'h08;
        do_reset();
        wait_valid("irm0", lat);
        check("irm0_lat",   64'(lat),        64'd2);
        check("irm0_icode", 64'(out_icode),  64'h3);
        check("irm0_rA",    64'(out_rA),     64'hF);
        check("irm0_rB",    64'(out_rB),     64'h8);
        check("irm0_valC",  out_valC,        64'h8);
        check("irm0_valP",  out_valP,        64'hA);
        check("irm0_stat",  64'(out_stat),   64'h1);
        check("irm0_nreq",  64'(req_log.size()), 64'd2);
        check("irm0_req0",  log_at(0),       64'h0);
        check("irm0_req1",  log_at(1),       64'h8);

        // backpressure: 5 cycles without out_ready
        snap_valC = out_valC; snap_pc = out_pc; snap_valP = out_valP;
        snap_icode = out_icode; snap_rB = out_rB;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || imem_req || out_valC !== snap_valC || out_pc !== snap_pc ||
                out_valP !== snap_valP || out_icode !== snap_icode || out_rB !== snap_rB)
                bad = 1'b1;
        end
        check("bp_stable", 64'(bad), 64'h0);
        accept();
        check("irm0_after_valid", 64'(out_valid), 64'h0);
        check("irm0_next_req",    64'(imem_req),  64'h1);
        check("irm0_next_addr",   imem_addr,      64'h8);

        // irmovq at pc 7 (reached by a redirect acked in the same cycle): three words
        clear_mem();
        mem[7] = 8'h30; mem[8] = 8'hF8; mem[9] = 8'h08;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 64'h7;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_valid("irm7", lat);
        check("irm7_pc",    out_pc,         64'h7);
        check("irm7_icode", 64'(out_icode), 64'h3);
        check("irm7_rB",    64'(out_rB),    64'h8);
        check("irm7_valC",  out_valC,       64'h8);
        check("irm7_valP",  out_valP,       64'h11);
        check("irm7_stat",  64'(out_stat),  64'h1);
        check("irm7_nreq",  64'(req_log.size()), 64'd4);
        check("irm7_req1",  log_at(1),      64'h0);
        check("irm7_req2",  log_at(2),      64'h8);
        check("irm7_req3",  log_at(3),      64'h10);

        // halt at pc 0
        clear_mem();
        do_reset();
        wait_valid("hlt", lat);
        check("hlt_stat",  64'(out_stat),  64'h2);
        check("hlt_icode", 64'(out_icode), 64'h0);
        check("hlt_valP",  out_valP,       64'h1);
        check("hlt_rA",    64'(out_rA),    64'hF);
        accept();
        check("hlt_halted", 64'(halted),    64'h1);
        check("hlt_valid",  64'(out_valid), 64'h0);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req || !halted || out_valid)
                bad = 1'b1;
        end
        check("hlt_idle", 64'(bad), 64'h0);

        // invalid opcode 0xC0
        clear_mem();
        mem[0] = 8'hC0;
        do_reset();
        wait_valid("ins", lat);
        check("ins_stat",  64'(out_stat),  64'h4);
        check("ins_icode", 64'(out_icode), 64'hC);
        check("ins_valP",  out_valP,       64'h1);
        accept();
        check("ins_halted", 64'(halted), 64'h1);

        // jmp with address error on the second word
        clear_mem();
        mem[0] = 8'h70;
        err_en = 1'b1;
        err_addr = 64'h8;
        do_reset();
        wait_valid("adr", lat);
        check("adr_stat", 64'(out_stat), 64'h3);
        check("adr_pc",   out_pc,        64'h0);
        check("adr_nreq", 64'(req_log.size()), 64'd2);
        accept();
        check("adr_halted", 64'(halted), 64'h1);
        err_en = 1'b0;

        // redirect to 0x40 while the first ack is delayed 3 cycles
        clear_mem();
        mem[0] = 8'h10;
        mem[8'h40] = 8'h60; mem[8'h41] = 8'h23;
        ack_delay = 3;
        do_reset();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_valid("rdr", lat);
        check("rdr_pc",    out_pc,         64'h40);
        check("rdr_icode", 64'(out_icode), 64'h6);
        check("rdr_ifun",  64'(out_ifun),  64'h0);
        check("rdr_rA",    64'(out_rA),    64'h2);
        check("rdr_rB",    64'(out_rB),    64'h3);
        check("rdr_valP",  out_valP,       64'h42);
        check("rdr_nreq",  64'(req_log.size()), 64'd2);
        check("rdr_req1",  log_at(1),      64'h40);

        // redirect together with out_ready in OUT: not a transfer
        ack_delay = 0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        check("rdo_valid", 64'(out_valid), 64'h0);
        check("rdo_addr",  imem_addr,      64'h40);
        wait_valid("rdo", lat);
        check("rdo_pc",    out_pc,         64'h40);
        check("rdo_icode", 64'(out_icode), 64'h6);

        // reset in the middle of a fetch from 0x80
        ack_delay = 5;
        redirect_valid = 1'b1;
        redirect_pc = 64'h80;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("mid_req",  64'(imem_req), 64'h1);
        check("mid_addr", imem_addr,     64'h80);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req",   64'(imem_req),  64'h0);
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        rst = 1'b0;
        #1;
        check("mid_post_req",   64'(imem_req),  64'h1);
        check("mid_post_addr",  imem_addr,      64'h0);
        check("mid_post_valid", 64'(out_valid), 64'h0);
        wait_valid("mid", lat);
        check("mid_pc",    out_pc,         64'h0);
        check("mid_icode", 64'(out_icode), 64'h1);
        check("mid_valP",  out_valP,       64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
